// File: rtl/uart_icb_regs.sv
// uart_icb_regs: ICB slave register block for the UART.
//
// Holds the received bytes in an RX FIFO, reports status, drives the
// baud/parity configuration, and pushes bytes into the UART TX FIFO.
// Interrupts are raised per source through the IE/IP registers.
// Addresses 6 and 7 (addr[4:2]) answer with err = 1.
//
// Optional feature: define UART_RX_TIMEOUT_EN to build the RX idle-timeout
// counter that drives IP[3]. When it is undefined, IP[3] reads 0 and
// IE[3] is stored but has no effect.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   icb_cmd_* / icb_rsp_*       ICB command and response channels
//   irq_o                       registered level interrupt, |(IP & IE)
//   fifowrfull/fifowrreq/fifowdata   TX FIFO full flag, push strobe, byte
//   rxdata/rxdataupdate/parityerror/frameerror   RX deserializer
//   tx_cnt, rx_cnt, parity      baud divisors and parity mode from CTRL
module uart_icb_regs #(
    parameter int RX_DEPTH    = 16,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icb_cmd_vld,
    output logic        icb_cmd_rdy,
    input  logic        icb_cmd_read,
    input  logic [11:0] icb_cmd_addr,
    input  logic [31:0] icb_cmd_wdata,
    input  logic [3:0]  icb_cmd_wmask,
    output logic        icb_rsp_vld,
    input  logic        icb_rsp_rdy,
    output logic [31:0] icb_rsp_rdata,
    output logic        icb_rsp_err,
    output logic        irq_o,
    input  logic        fifowrfull,
    output logic        fifowrreq,
    output logic [7:0]  fifowdata,
    input  logic [7:0]  rxdata,
    input  logic        rxdataupdate,
    input  logic        parityerror,
    input  logic        frameerror,
    output logic [11:0] tx_cnt,
    output logic [8:0]  rx_cnt,
    output logic [1:0]  parity
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = $clog2(RX_DEPTH + 1);

    logic        rsp_vld_q, rsp_err_q, irq_q, tx_req_q;
    logic [31:0] rsp_rdata_q, rd_val;
    logic [7:0]  tx_data_q;
    logic [22:0] ctrl_q, ctrl_d;
    logic [3:0]  ie_q, ie_d;
    logic [3:1]  ip_q, ip_d, ip_set, ip_clr;
    logic [2:0]  sel;
    logic        accept, is_wr, unmapped;

    // RX input sampling: one register stage, then edge detect
    logic        rx_upd_q, rx_upd_prev_q;
    logic [9:0]  rx_in_q;
    logic [9:0]  rx_mem_q [RX_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] rx_count_q;
    logic        rx_push, rx_pop, rx_wr_en, rx_empty, rx_full, overrun_set;
    logic        tx_wr, tx_push, tx_drop_set, to_set;
    logic        unused_ok;

    assign unused_ok = ^{icb_cmd_addr[11:5], icb_cmd_addr[1:0],
                         icb_cmd_wdata[31:23], icb_cmd_wmask[3]};

    assign icb_cmd_rdy = ~rsp_vld_q | icb_rsp_rdy;
    assign accept      = icb_cmd_vld & icb_cmd_rdy;
    assign is_wr       = ~icb_cmd_read;
    assign sel         = icb_cmd_addr[4:2];
    assign unmapped    = sel[2] & sel[1];

    assign rx_empty    = (rx_count_q == '0);
    assign rx_full     = (rx_count_q == CW'(RX_DEPTH));
    assign rx_push     = rx_upd_q & ~rx_upd_prev_q;
    assign rx_pop      = accept & icb_cmd_read & (sel == 3'd0) & ~rx_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign rx_wr_en    = rx_push & (~rx_full | rx_pop);
    assign overrun_set = rx_push & rx_full & ~rx_pop;

    assign tx_wr       = accept & is_wr & (sel == 3'd1) & icb_cmd_wmask[0];
    assign tx_push     = tx_wr & ~fifowrfull;
    assign tx_drop_set = tx_wr & fifowrfull;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_upd_q      <= 1'b0;
            rx_upd_prev_q <= 1'b0;
            rx_in_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rx_count_q    <= '0;
        end else begin
            rx_upd_q      <= rxdataupdate;
            rx_upd_prev_q <= rx_upd_q;
            rx_in_q       <= {frameerror, parityerror, rxdata};
            if (rx_wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rx_pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({rx_wr_en, rx_pop})
                2'b10:   rx_count_q <= rx_count_q + CW'(1);
                2'b01:   rx_count_q <= rx_count_q - CW'(1);
                default: rx_count_q <= rx_count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_wr_en) rx_mem_q[wr_ptr_q] <= rx_in_q;
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] to_cnt_q;
    logic          to_fired_q, to_clr, to_hit;

    assign to_clr = rx_push | rx_pop | rx_empty;
    assign to_hit = (to_cnt_q == TW'(TIMEOUT_CYC - 1));
    // Fires once per idle period; the counter then sits at the threshold
    assign to_set = ~to_clr & to_hit & ~to_fired_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_q   <= '0;
            to_fired_q <= 1'b0;
        end else if (to_clr) begin
            to_cnt_q   <= '0;
            to_fired_q <= 1'b0;
        end else begin
            if (!to_hit) to_cnt_q <= to_cnt_q + TW'(1);
            if (to_set)  to_fired_q <= 1'b1;
        end
    end
`else
    assign to_set = 1'b0;
`endif

    always_comb begin
        ctrl_d = ctrl_q;
        ie_d   = ie_q;
        ip_clr = '0;
        if (accept && is_wr) begin
            if (sel == 3'd3) begin
                if (icb_cmd_wmask[0]) ctrl_d[7:0]   = icb_cmd_wdata[7:0];
                if (icb_cmd_wmask[1]) ctrl_d[15:8]  = icb_cmd_wdata[15:8];
                if (icb_cmd_wmask[2]) ctrl_d[22:16] = icb_cmd_wdata[22:16];
            end
            if (sel == 3'd4 && icb_cmd_wmask[0]) ie_d = icb_cmd_wdata[3:0];
            if (sel == 3'd5 && icb_cmd_wmask[0]) ip_clr = icb_cmd_wdata[3:1];
        end
        ip_set = {to_set, tx_drop_set, overrun_set};
        // Set is applied after clear so a simultaneous event is not lost
        ip_d   = (ip_q & ~ip_clr) | ip_set;
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            3'd0: if (!rx_empty) rd_val = {21'b0, 1'b1, rx_mem_q[rd_ptr_q]};
            3'd2: rd_val = {16'b0, 8'(rx_count_q), 5'b0, fifowrfull, rx_full, rx_empty};
            3'd3: rd_val = {9'b0, ctrl_q};
            3'd4: rd_val = {28'b0, ie_q};
            3'd5: rd_val = {28'b0, ip_q, ~rx_empty};
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q      <= 23'h145A2B;
            ie_q        <= '0;
            ip_q        <= '0;
            irq_q       <= 1'b0;
            tx_req_q    <= 1'b0;
            tx_data_q   <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            ie_q     <= ie_d;
            ip_q     <= ip_d;
            irq_q    <= |({ip_q, ~rx_empty} & ie_q);
            tx_req_q <= tx_push;
            if (tx_push) tx_data_q <= icb_cmd_wdata[7:0];
            if (accept) begin
                rsp_vld_q   <= 1'b1;
                rsp_rdata_q <= icb_cmd_read ? rd_val : 32'b0;
                rsp_err_q   <= unmapped;
            end else if (icb_rsp_rdy) begin
                rsp_vld_q   <= 1'b0;
            end
        end
    end

    assign icb_rsp_vld   = rsp_vld_q;
    assign icb_rsp_rdata = rsp_rdata_q;
    assign icb_rsp_err   = rsp_err_q;
    assign irq_o         = irq_q;
    assign fifowrreq     = tx_req_q;
    assign fifowdata     = tx_data_q;
    assign tx_cnt        = ctrl_q[11:0];
    assign rx_cnt        = ctrl_q[20:12];
    assign parity        = ctrl_q[22:21];
endmodule

// File: tb/tb_uart_icb_regs.sv
module tb_uart_icb_regs;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld, rdy, rd, rsp_vld, rsp_rdy, rsp_err, irq;
    logic [11:0] addr;
    logic [31:0] wdata, rsp_rdata;
    logic [3:0]  wmask;
    logic        wrfull, wrreq, upd, pe, fe;
    logic [7:0]  wdat_tx, rxd;
    logic [11:0] tx_cnt;
    logic [8:0]  rx_cnt;
    logic [1:0]  parity;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_icb_regs #(.RX_DEPTH(DEPTH), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_vld(vld), .icb_cmd_rdy(rdy), .icb_cmd_read(rd),
        .icb_cmd_addr(addr), .icb_cmd_wdata(wdata), .icb_cmd_wmask(wmask),
        .icb_rsp_vld(rsp_vld), .icb_rsp_rdy(rsp_rdy),
        .icb_rsp_rdata(rsp_rdata), .icb_rsp_err(rsp_err), .irq_o(irq),
        .fifowrfull(wrfull), .fifowrreq(wrreq), .fifowdata(wdat_tx),
        .rxdata(rxd), .rxdataupdate(upd), .parityerror(pe), .frameerror(fe),
        .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .parity(parity)
    );

    typedef struct {
        logic        rd;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic r, input logic [11:0] a, input logic [31:0] wd,
                        input logic [3:0] wm, output logic [31:0] rdat, output logic err);
        int n = 0;
        @(negedge clk);
        rsp_rdy = 1'b1; vld = 1'b1; rd = r; addr = a; wdata = wd; wmask = wm;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) begin
            total++; bad++;
            $display("FAIL cmd_rdy_timeout: got 0 want 1");
        end
        @(negedge clk);
        vld = 1'b0;
        chk("rsp_vld", 32'(rsp_vld), 32'd1);
        rdat = rsp_rdata;
        err  = rsp_err;
    endtask

    task automatic reg_rd(input logic [11:0] a, input logic [31:0] exp, input string name);
        logic [31:0] d;
        logic        e;
        xfer(1'b1, a, 32'h0, 4'h0, d, e);
        chk(name, d, exp);
    endtask

    task automatic reg_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] rdat;
        logic        e;
        xfer(1'b0, a, d, m, rdat, e);
    endtask

    task automatic rx_push(input logic [7:0] b, input logic p, input logic f);
        @(negedge clk);
        rxd = b; pe = p; fe = f; upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          first;

        rst_n = 1'b0; vld = 1'b0; rd = 1'b0; addr = '0; wdata = '0; wmask = '0;
        rsp_rdy = 1'b1; wrfull = 1'b0; upd = 1'b0; rxd = '0; pe = 1'b0; fe = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_wrreq", 32'(wrreq), 32'd0);
        chk("rst_wdata", 32'(wdat_tx), 32'd0);
        chk("rst_tx_cnt", 32'(tx_cnt), 32'd2603);
        chk("rst_rx_cnt", 32'(rx_cnt), 32'd325);
        chk("rst_parity", 32'(parity), 32'd0);
        chk("rst_cmd_rdy", 32'(rdy), 32'd1);

        vt.push_back('{1'b1, 12'h00C, 32'h0, 4'h0, 32'h00145A2B, 1'b0, "ctrl_rst"});
        vt.push_back('{1'b1, 12'h008, 32'h0, 4'h0, 32'h00000001, 1'b0, "status_rst"});
        vt.push_back('{1'b1, 12'h014, 32'h0, 4'h0, 32'h0, 1'b0, "ip_rst"});
        vt.push_back('{1'b1, 12'h010, 32'h0, 4'h0, 32'h0, 1'b0, "ie_rst"});
        vt.push_back('{1'b1, 12'h000, 32'h0, 4'h0, 32'h0, 1'b0, "rxdata_empty"});
        vt.push_back('{1'b1, 12'h004, 32'h0, 4'h0, 32'h0, 1'b0, "txdata_rd"});
        vt.push_back('{1'b1, 12'h018, 32'h0, 4'h0, 32'h0, 1'b1, "unmapped6_rd"});
        vt.push_back('{1'b1, 12'h01C, 32'h0, 4'h0, 32'h0, 1'b1, "unmapped7_rd"});
        vt.push_back('{1'b0, 12'h018, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "unmapped6_wr"});
        vt.push_back('{1'b0, 12'h00C, 32'hFFFFFFFF, 4'h4, 32'h0, 1'b0, "ctrl_wr_b2"});
        vt.push_back('{1'b1, 12'h00C, 32'h0, 4'h0, 32'h007F5A2B, 1'b0, "ctrl_b2"});
        vt.push_back('{1'b0, 12'h00D, 32'h00000003, 4'h1, 32'h0, 1'b0, "ctrl_wr_b0"});
        vt.push_back('{1'b1, 12'h00F, 32'h0, 4'h0, 32'h007F5A03, 1'b0, "ctrl_b0"});
        vt.push_back('{1'b0, 12'h00C, 32'h00145A2B, 4'hF, 32'h0, 1'b0, "ctrl_wr_all"});
        vt.push_back('{1'b1, 12'h00C, 32'h0, 4'h0, 32'h00145A2B, 1'b0, "ctrl_restored"});
        vt.push_back('{1'b0, 12'h010, 32'hFFFFFFFF, 4'h1, 32'h0, 1'b0, "ie_wr"});
        vt.push_back('{1'b1, 12'h010, 32'h0, 4'h0, 32'h0000000F, 1'b0, "ie_all"});
        vt.push_back('{1'b0, 12'h010, 32'h0, 4'h0, 32'h0, 1'b0, "ie_wr_nomask"});
        vt.push_back('{1'b1, 12'h010, 32'h0, 4'h0, 32'h0000000F, 1'b0, "ie_kept"});
        vt.push_back('{1'b0, 12'h010, 32'h0, 4'h1, 32'h0, 1'b0, "ie_clr"});
        vt.push_back('{1'b1, 12'h010, 32'h0, 4'h0, 32'h0, 1'b0, "ie_zero"});
        vt.push_back('{1'b1, 12'h008, 32'h0, 4'h0, 32'h00000001, 1'b0, "status_after"});

        foreach (vt[i]) begin
            xfer(vt[i].rd, vt[i].addr, vt[i].wdata, vt[i].wmask, d, e);
            if (vt[i].rd || vt[i].exp_err) chk({vt[i].name, "_rdata"}, d, vt[i].exp_rdata);
            chk({vt[i].name, "_err"}, 32'(e), 32'(vt[i].exp_err));
        end

        // CTRL fields drive the configuration outputs
        reg_wr(12'h00C, 32'h00664032, 4'hF);
        chk("cfg_parity", 32'(parity), 32'd3);
        chk("cfg_rx_cnt", 32'(rx_cnt), 32'd100);
        chk("cfg_tx_cnt", 32'(tx_cnt), 32'd50);
        reg_wr(12'h00C, 32'h00145A2B, 4'hF);

        // Three received bytes, the middle one with a parity error
        rx_push(8'h41, 1'b0, 1'b0);
        rx_push(8'h42, 1'b1, 1'b0);
        rx_push(8'h43, 1'b0, 1'b0);
        reg_rd(12'h008, 32'h00000300, "status_3");
        reg_rd(12'h014, 32'h00000001, "ip_nonempty");
        reg_rd(12'h000, 32'h00000441, "rx_0x41");
        reg_rd(12'h000, 32'h00000542, "rx_0x42");
        reg_rd(12'h000, 32'h00000443, "rx_0x43");
        reg_rd(12'h000, 32'h00000000, "rx_4th_empty");

        // Overrun: DEPTH+1 pushes, last one dropped
        for (int i = 0; i <= DEPTH; i++) rx_push(8'h10 + 8'(i), 1'b0, 1'b0);
        reg_rd(12'h008, 32'h00000402, "status_full");
        reg_rd(12'h014, 32'h00000003, "ip_overrun");
        reg_wr(12'h010, 32'h2, 4'h1);
        @(negedge clk);
        chk("irq_overrun", 32'(irq), 32'd1);
        reg_wr(12'h014, 32'h2, 4'h1);
        @(negedge clk);
        @(negedge clk);
        chk("irq_cleared", 32'(irq), 32'd0);
        reg_rd(12'h014, 32'h00000001, "ip_w1c");
        for (int i = 0; i < DEPTH; i++) reg_rd(12'h000, 32'h410 + 32'(i), "rx_drain");
        reg_rd(12'h008, 32'h00000001, "status_drained");
        reg_wr(12'h010, 32'h0, 4'h1);

        // Push and pop on the same edge with the FIFO full
        for (int i = 0; i < DEPTH; i++) rx_push(8'h20 + 8'(i), 1'b0, 1'b0);
        @(negedge clk);
        rxd = 8'h77; pe = 1'b0; fe = 1'b0; upd = 1'b1;
        @(negedge clk);
        upd = 1'b0; vld = 1'b1; rd = 1'b1; addr = 12'h000; rsp_rdy = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        chk("pushpop_rdata", rsp_rdata, 32'h00000420);
        reg_rd(12'h008, 32'h00000402, "pushpop_status");
        reg_rd(12'h014, 32'h00000001, "pushpop_no_overrun");
        for (int i = 1; i < DEPTH; i++) reg_rd(12'h000, 32'h420 + 32'(i), "pushpop_drain");
        reg_rd(12'h000, 32'h00000477, "pushpop_last");

        // TX push with and without room
        @(negedge clk);
        vld = 1'b1; rd = 1'b0; addr = 12'h004; wdata = 32'h55; wmask = 4'h1;
        @(negedge clk);
        vld = 1'b0;
        chk("tx_req_pulse", 32'(wrreq), 32'd1);
        chk("tx_data", 32'(wdat_tx), 32'h55);
        @(negedge clk);
        chk("tx_req_end", 32'(wrreq), 32'd0);
        wrfull = 1'b1;
        vld = 1'b1; rd = 1'b0; addr = 12'h004; wdata = 32'hAA; wmask = 4'h1;
        @(negedge clk);
        vld = 1'b0;
        chk("tx_full_noreq", 32'(wrreq), 32'd0);
        chk("tx_full_data", 32'(wdat_tx), 32'h55);
        reg_rd(12'h008, 32'h00000005, "status_txfull");
        reg_rd(12'h014, 32'h00000004, "ip_txdrop");
        wrfull = 1'b0;
        reg_wr(12'h014, 32'h4, 4'h1);
        reg_rd(12'h014, 32'h00000000, "ip_txdrop_clr");

        // Response back-pressure: second command must wait
        @(negedge clk);
        vld = 1'b1; rd = 1'b1; addr = 12'h00C; rsp_rdy = 1'b0;
        @(negedge clk);
        addr = 12'h008;
        for (int i = 0; i < 5; i++) begin
            chk("bp_cmd_rdy", 32'(rdy), 32'd0);
            chk("bp_rdata", rsp_rdata, 32'h00145A2B);
            @(negedge clk);
        end
        rsp_rdy = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        chk("bp_next_rdata", rsp_rdata, 32'h00000001);
        @(negedge clk);
        chk("bp_rsp_done", 32'(rsp_vld), 32'd0);

        // RX idle timeout
        reg_wr(12'h010, 32'h8, 4'h1);
        @(negedge clk);
        rxd = 8'h99; upd = 1'b1;
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) upd = 1'b0;
            if (irq && first < 0) first = k;
        end
`ifdef UART_RX_TIMEOUT_EN
        chk("timeout_irq_cycle", 32'(first), 32'd11);
        reg_rd(12'h014, 32'h00000009, "ip_timeout");
`else
        chk("timeout_irq_none", 32'(first), 32'hFFFFFFFF);
        reg_rd(12'h014, 32'h00000001, "ip_no_timeout");
`endif
        reg_wr(12'h014, 32'h8, 4'h1);
        repeat (20) @(negedge clk);
        reg_rd(12'h014, 32'h00000001, "timeout_once");
        reg_wr(12'h010, 32'h0, 4'h1);
        reg_rd(12'h000, 32'h00000499, "rx_0x99");

        // Reset with a response pending
        reg_wr(12'h00C, 32'h00600000, 4'h4);
        @(negedge clk);
        vld = 1'b1; rd = 1'b1; addr = 12'h00C; rsp_rdy = 1'b0;
        @(negedge clk);
        vld = 1'b0;
        chk("pre_rst_rsp_vld", 32'(rsp_vld), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_rdy = 1'b1;
        chk("mid_rst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("mid_rst_rdata", rsp_rdata, 32'h0);
        chk("mid_rst_wdata", 32'(wdat_tx), 32'd0);
        reg_rd(12'h00C, 32'h00145A2B, "ctrl_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
